// File: rtl/led_cnt_pkg.sv
// Shared constants and helpers for the led_cnt_bank block.
package led_cnt_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // A one-channel bank still needs a 1-bit select field.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_cnt_bank_if.sv
// Configuration write port: valid/ready handshake carrying target channel and divide value.
interface led_cnt_bank_if
  import led_cnt_pkg::*;
#(
  parameter int NCH   = 2,
  parameter int PRE_W = 24
) ();

  localparam int CH_W = ch_w(NCH);

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [PRE_W-1:0] cfg_div;

  modport master (output cfg_valid, cfg_ch, cfg_div, input  cfg_ready);
  modport slave  (input  cfg_valid, cfg_ch, cfg_div, output cfg_ready);

endinterface

// File: rtl/led_cnt_chan.sv
// One LED channel: prescaler, programmable divide register, wrapping counter and tick pulse.
module led_cnt_chan
  import led_cnt_pkg::*;
#(
  parameter int               PRE_W       = 24,
  parameter int               OUT_W       = 4,
  parameter logic [PRE_W-1:0] DEFAULT_DIV = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             cfg_we,
  input  logic [PRE_W-1:0] cfg_div,
  output logic             tick,
  output logic [OUT_W-1:0] cnt
);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [PRE_W-1:0] div_q, div_d;
  logic [OUT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  always_comb begin
    // NOTE: every _d gets a hold/default value first, so no path leaves it unassigned and no latch is inferred.
    pre_d  = pre_q;
    div_d  = div_q;
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (cfg_we) begin
      // A write restarts the period and suppresses any terminal on this edge.
      div_d = cfg_div;
      pre_d = '0;
    end else if (en) begin
      if (pre_q == div_q) begin
        pre_d  = '0;
        tick_d = 1'b1;
        cnt_d  = (dir == DIR_UP) ? cnt_q + OUT_W'(1) : cnt_q - OUT_W'(1);
      end else begin
        pre_d = pre_q + PRE_W'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q  <= '0;
      div_q  <= DEFAULT_DIV;
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;
  assign cnt  = cnt_q;

endmodule

// File: rtl/led_cnt_bank.sv
// Bank of NCH clock-enable-cascaded LED counters sharing one config write port; all flops on clk.
module led_cnt_bank
  import led_cnt_pkg::*;
#(
  parameter int               NCH         = 2,
  parameter int               PRE_W       = 24,
  parameter int               OUT_W       = 4,
  parameter logic [PRE_W-1:0] DEFAULT_DIV = '1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       en,
  input  logic [NCH-1:0]       dir,
  led_cnt_bank_if.slave        cfg,
  output logic [NCH-1:0]       tick,
  output logic [NCH*OUT_W-1:0] leds
);

  localparam int CH_W = ch_w(NCH);

  logic           cfg_ready_q;
  logic           cfg_accept;
  logic [NCH-1:0] cfg_we;

  always_ff @(posedge clk) begin
    if (rst) cfg_ready_q <= 1'b0;
    else     cfg_ready_q <= 1'b1;
  end

  assign cfg.cfg_ready = cfg_ready_q;
  assign cfg_accept    = cfg.cfg_valid & cfg_ready_q;

  // Out-of-range channel numbers match no decoder output, so such writes are absorbed silently.
  for (genvar i = 0; i < NCH; i++) begin : g_chan
    assign cfg_we[i] = cfg_accept && (cfg.cfg_ch == CH_W'(i));

    led_cnt_chan #(
      .PRE_W       (PRE_W),
      .OUT_W       (OUT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .en      (en[i]),
      .dir     (dir[i]),
      .cfg_we  (cfg_we[i]),
      .cfg_div (cfg.cfg_div),
      .tick    (tick[i]),
      .cnt     (leds[i*OUT_W +: OUT_W])
    );
  end

endmodule
